// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
  localparam int IMEM_DEPTH = 64;
  localparam int INSTR_WIDTH_DEF = 32;
  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction
  localparam int BPW = bytes_per_word(INSTR_WIDTH_DEF);
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts big-endian bytes into a word and flags the byte that completes it
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   take,
  input  logic [7:0]             byte_in,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_full
);
  localparam int NB = bytes_per_word(INSTR_WIDTH);
  localparam int CW = $clog2(NB + 1);
  logic [INSTR_WIDTH-1:0] shift;
  logic [CW-1:0] cnt;
  // word is the value the shift register takes if this byte is accepted; word_full marks the final byte
  always_comb begin
    word = {shift[INSTR_WIDTH-9:0], byte_in};
    word_full = take && cnt == CW'(NB - 1);
  end
  // shift register and byte counter, wiped between words and on reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift <= '0;
      cnt <= '0;
    end else if (take) begin
      shift <= word;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into words, writes them from address 0 and holds the CPU until done
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = INSTR_WIDTH_DEF,
  parameter int DEPTH         = IMEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] word_count,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       wr_en,
  output logic [ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [INSTR_WIDTH-1:0]     wr_data,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       error
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NB = bytes_per_word(INSTR_WIDTH);
  state_t state;
  logic [CW-1:0] count, index;
  logic take, ok, word_full;
  logic [INSTR_WIDTH-1:0] word;
  // a byte moves only while LOAD advertises ready; word_count is legal in 1..DEPTH
  always_comb begin
    take = byte_valid && byte_ready;
    ok = word_count != '0 && word_count <= CW'(DEPTH);
  end
  imem_loader_byte_packer #(.INSTR_WIDTH(INSTR_WIDTH)) u_packer (
    .clk(clk),
    .rst(rst),
    .clear(state != LOAD),
    .take(take),
    .byte_in(byte_in),
    .word(word),
    .word_full(word_full)
  );
  // control FSM with registered outputs; a completed word is strobed out in the single WRITE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      index <= '0;
      byte_ready <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cpu_hold <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          done <= 1'b0;
          error <= !ok;
          cpu_hold <= 1'b1;
          count <= word_count;
          index <= '0;
          byte_ready <= ok;
          state <= ok ? LOAD : ERR;
        end
        LOAD: if (word_full) begin
          byte_ready <= 1'b0;
          wr_en <= 1'b1;
          wr_data <= word;
          wr_addr <= ADDRESS_WIDTH'(index) * ADDRESS_WIDTH'(NB);
          state <= WRITE;
        end
        WRITE: begin
          index <= index + CW'(1);
          if (index + CW'(1) == count) begin
            state <= DONE;
            done <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the instruction memory loader
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic clk = 0, rst = 1, start = 0, byte_valid = 0;
  logic [6:0] word_count = '0;
  logic [7:0] byte_in = '0;
  logic byte_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] wa[$], wd[$];
  int wc[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) begin
    wa.push_back(wr_addr);
    wd.push_back(wr_data);
    wc.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1;
    word_count = 7'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte_ready stayed 0, required 1 within 100 cycles");
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_done(output int c);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b required 1 within 400 cycles", done);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, cpu_hold, done, error} !== 5'b00100 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/we/hold/done/err=%b addr=%h data=%h required 00100 0 0",
               {byte_ready, wr_en, cpu_hold, done, error}, wr_addr, wr_data);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic check_two(input string nm);
    checks++;
    if (wa.size() !== 2) begin
      errors++;
      $display("FAIL %s_count: writes=%0d required 2", nm, wa.size());
    end else begin
      checks++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h20080005) begin
        errors++;
        $display("FAIL %s_w0: addr=%h data=%h required 0 20080005", nm, wa[0], wd[0]);
      end
      checks++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h0000000C) begin
        errors++;
        $display("FAIL %s_w1: addr=%h data=%h required 4 0000000c", nm, wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_basic();
    int dc;
    clear_log();
    do_start(2);
    send_word(32'h20080005, 0);
    send_word(32'h0000000C, 0);
    wait_done(dc);
    check_two("basic");
    if (wc.size() == 2) begin
      checks++;
      if (wc[1] - wc[0] !== 5) begin
        errors++;
        $display("FAIL basic_gap: strobe gap=%0d required 5", wc[1] - wc[0]);
      end
      checks++;
      if (dc - wc[1] !== 1) begin
        errors++;
        $display("FAIL basic_done_lat: done after %0d cycles required 1", dc - wc[1]);
      end
    end
    checks++;
    if (cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_state: hold=%b rdy=%b required 0 0", cpu_hold, byte_ready);
    end
  endtask

  task automatic test_gaps();
    int dc;
    clear_log();
    do_start(2);
    send_word(32'h20080005, 1);
    send_word(32'h0000000C, 1);
    wait_done(dc);
    repeat (5) @(negedge clk);
    check_two("gaps");
  endtask

  task automatic test_errors();
    int dc;
    clear_log();
    do_start(0);
    @(negedge clk);
    checks++;
    if ({error, cpu_hold, done, byte_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL err_zero: err/hold/done/rdy=%b required 1100", {error, cpu_hold, done, byte_ready});
    end
    do_start(65);
    byte_valid = 1;
    repeat (4) @(negedge clk);
    byte_valid = 0;
    checks++;
    if ({error, cpu_hold, done, byte_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL err_65: err/hold/done/rdy=%b required 1100", {error, cpu_hold, done, byte_ready});
    end
    checks++;
    if (wa.size() !== 0) begin
      errors++;
      $display("FAIL err_no_write: writes=%0d required 0", wa.size());
    end
    do_start(1);
    checks++;
    if (error !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_recover: err=%b rdy=%b required 0 1", error, byte_ready);
    end
    send_word(32'h12345678, 0);
    wait_done(dc);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL err_reload: writes=%0d addr=%h data=%h required 1 0 12345678",
               wa.size(), wa.size() ? wa[0] : 32'hx, wd.size() ? wd[0] : 32'hx);
    end
  endtask

  task automatic test_full();
    int dc, bad = 0;
    logic [31:0] mx = 0;
    clear_log();
    do_start(64);
    for (int k = 0; k < 64; k++) send_word({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 0);
    wait_done(dc);
    repeat (5) @(negedge clk);
    checks++;
    if (wa.size() !== 64) begin
      errors++;
      $display("FAIL full_count: writes=%0d required 64", wa.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (wa[k] !== 32'(4*k) || wd[k] !== {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}) bad++;
        if (wa[k] > mx) mx = wa[k];
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL full_words: %0d words wrong required 0", bad);
      end
      checks++;
      if (wa[63] !== 32'hFC || wd[63] !== 32'hFCFDFEFF || mx >= 32'h100) begin
        errors++;
        $display("FAIL full_last: addr=%h data=%h max=%h required fc fcfdfeff <100", wa[63], wd[63], mx);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    clear_log();
    do_start(1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (dut.state !== IDLE || cpu_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: state=%0d hold=%b done=%b rdy=%b required IDLE 1 0 0",
               dut.state, cpu_hold, done, byte_ready);
    end
    byte_in = 8'hCC;
    byte_valid = 1;
    repeat (10) @(negedge clk);
    byte_valid = 0;
    checks++;
    if (wa.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_no_write: writes=%0d required 0", wa.size());
    end
    do_start(1);
    send_word(32'hDEADBEEF, 0);
    wait_done(dc);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rstmid_fresh: writes=%0d addr=%h data=%h required 1 0 deadbeef",
               wa.size(), wa.size() ? wa[0] : 32'hx, wd.size() ? wd[0] : 32'hx);
    end
  endtask

  task automatic test_restart();
    int dc;
    clear_log();
    do_start(2);
    send_byte(8'h20, 0);
    send_byte(8'h08, 0);
    start = 1;
    word_count = 7'd5;
    send_byte(8'h00, 0);
    start = 0;
    send_byte(8'h05, 0);
    send_word(32'h0000000C, 0);
    wait_done(dc);
    repeat (3) @(negedge clk);
    check_two("ignore_start");
    clear_log();
    do_start(1);
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_hold: hold=%b done=%b required 1 0", cpu_hold, done);
    end
    send_word(32'hCAFEF00D, 0);
    wait_done(dc);
    checks++;
    if (wa.size() !== 1 || wa[0] !== 32'h0 || wd[0] !== 32'hCAFEF00D || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL restart_write: writes=%0d addr=%h data=%h hold=%b required 1 0 cafef00d 0",
               wa.size(), wa.size() ? wa[0] : 32'hx, wd.size() ? wd[0] : 32'hx, cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_errors();
    test_full();
    test_reset_mid();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
